uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_priority_select.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
package uart_tx_arbiter_pkg;

  // Widest word the uart transmitter accepts.
  localparam int UART_CONFIG_MAX_DATA = 8;

  // Idle cycles a held grant survives before it is revoked.
  localparam int UART_TX_ARB_TIMEOUT_DEFAULT = 1024;

  // Width of the idle (timeout) counter.
  localparam int TIMEOUT_CNT_W = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  // Index width for a requester vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_select.sv
// Round-robin search: first set request bit after last_idx, wrapping around.
module rr_priority_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk candidates last_idx+1 .. last_idx+NUM_REQ (mod NUM_REQ); first hit wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_idx) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid     = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart TX FIFO between NUM_REQ packet sources.
// A requester owns the FIFO from arbitration until its last word or until it
// stays idle for TIMEOUT usable cycles; FIFO back-pressure never counts as idle.
//
// state    | meaning
// ARB_IDLE | no owner; arbitrate round-robin when any request is valid
// ARB_OWN  | grant held; words of the owner pass straight to the FIFO
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = UART_CONFIG_MAX_DATA,
  parameter int TIMEOUT    = UART_TX_ARB_TIMEOUT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_write,
  input  logic                          tx_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int                       IDX_W          = idx_width(NUM_REQ);
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST   = TIMEOUT_CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]         LAST_OWNER_RST = IDX_W'(NUM_REQ - 1);

  arb_state_t               state_q, state_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]         owner_q, owner_d;
  logic [IDX_W-1:0]         last_owner_q, last_owner_d;
  logic [TIMEOUT_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                     timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0]       sel_gnt;
  logic [IDX_W-1:0]         sel_idx;
  logic                     sel_valid;

  logic                     accept_ok;
  logic                     xfer;
  logic                     idle_tick;
  logic                     timeout_hit;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_sel (
    .req       (req_valid),
    .last_idx  (last_owner_q),
    .gnt       (sel_gnt),
    .gnt_idx   (sel_idx),
    .gnt_valid (sel_valid)
  );

  // The owner may move a word only when the FIFO has room and ce is high.
  assign accept_ok = (state_q == ARB_OWN) && ce && !tx_full;
  assign req_ready = accept_ok ? grant_q : '0;
  assign xfer      = |(req_valid & req_ready);
  assign tx_write  = xfer;
  assign tx_data   = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];

  // Idle means the FIFO could take a word but the owner offers none, so an
  // idle cycle and a transfer can never coincide.
  assign idle_tick   = accept_ok && !req_valid[owner_q];
  assign timeout_hit = idle_tick && (idle_cnt_q == TIMEOUT_LAST);

  assign grant       = grant_q;
  assign busy        = (state_q == ARB_OWN);
  assign timeout_err = timeout_err_q;

  // Next-state logic: arbitration in IDLE, packet end / timeout release in OWN.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (ce && sel_valid) begin
          state_d    = ARB_OWN;
          grant_d    = sel_gnt;
          owner_d    = sel_idx;
          idle_cnt_d = '0;
        end
      end
      ARB_OWN: begin
        if (xfer) begin
          idle_cnt_d = '0;
          if (req_last[owner_q]) begin
            state_d      = ARB_IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
          end
        end else if (timeout_hit) begin
          state_d       = ARB_IDLE;
          grant_d       = '0;
          last_owner_d  = owner_q;
          idle_cnt_d    = '0;
          timeout_err_d = 1'b1;
        end else if (idle_tick) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register; reset wins over everything, including ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_owner_q  <= LAST_OWNER_RST;
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
